truth_table_extractor: RTL and testbench

TRUTH_TABLE_EXTRACTOR -- requirements
Module: truth_table_extractor

---
 rtl/truth_table_extractor_if.sv | 24 ++
 rtl/truth_table_extractor.sv | 121 ++++++++++++
 tb/tb_truth_table_extractor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_extractor_if.sv
// Handshake bundle between the truth-table extractor and the logic function
// under test plus the consumer of the captured table.
interface truth_table_extractor_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 abort;
   logic [N_IN-1:0]      stim;
   logic                 f_in;
   logic                 busy;
   logic [2**N_IN-1:0]   table_out;
   logic                 table_valid;
   logic                 table_ready;

   modport slave (
      input  start, abort, f_in, table_ready,
      output stim, busy, table_out, table_valid
   );

   modport master (
      output start, abort, f_in, table_ready,
      input  stim, busy, table_out, table_valid
   );
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps every input combination of an N_IN-input function, holds each for
// SETTLE cycles, samples f_in, and presents the full table until accepted.
module truth_table_extractor #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input logic                clk,
   input logic                rst,
   truth_table_extractor_if.slave bus
);

   localparam int              NV      = 2**N_IN;
   localparam int              IW      = N_IN + 1;
   localparam logic [IW-1:0]   LAST    = IW'(NV - 1);
   localparam logic [3:0]      CNT_RLD = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [NV-1:0]   tbl_q, tbl_d;

   logic            accept;
   assign accept = bus.start && !bus.abort;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_SETTLE;
         S_SETTLE: begin
            if (bus.abort)          state_d = S_IDLE;
            else if (cnt_q == 4'd0) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (bus.abort)          state_d = S_IDLE;
            else if (idx_q == LAST) state_d = S_DONE;
            else                    state_d = S_SETTLE;
         end
         S_DONE:   if (bus.table_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next-state; stim is the low bits of the index, so clearing the
   // index on abort or hand-off also returns stim to zero.
   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      tbl_d = tbl_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d = '0;
               cnt_d = CNT_RLD;
               tbl_d = '0;
            end
         end
         S_SETTLE: begin
            if (bus.abort) begin
               idx_d = '0;
               cnt_d = 4'd0;
               tbl_d = '0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (bus.abort) begin
               idx_d = '0;
               cnt_d = 4'd0;
               tbl_d = '0;
            end else begin
               tbl_d[idx_q[N_IN-1:0]] = bus.f_in;
               if (idx_q != LAST) begin
                  idx_d = idx_q + IW'(1);
                  cnt_d = CNT_RLD;
               end
            end
         end
         S_DONE: begin
            if (bus.table_ready) idx_d = '0;
         end
         default: begin
            idx_d = '0;
            cnt_d = 4'd0;
            tbl_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         cnt_q <= 4'd0;
         tbl_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         tbl_q <= tbl_d;
      end
   end

   always_comb begin
      bus.busy        = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      bus.table_valid = (state_q == S_DONE);
      bus.table_out   = tbl_q;
      bus.stim        = idx_q[N_IN-1:0];
   end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Three extractors (3/1, 3/3, 1/1) share start/abort/ready and are checked
// every cycle against a sweep-position model, plus literal table/latency pins.
module tb_truth_table_extractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, abort, ready, chk_en;
   int          mode;
   logic [63:0] lut;
   int          checks = 0;
   int          errors = 0;
   int          lat [3];

   truth_table_extractor_if #(.N_IN(3)) if0 ();
   truth_table_extractor_if #(.N_IN(3)) if1 ();
   truth_table_extractor_if #(.N_IN(1)) if2 ();

   // 0: in1&in(N), 1: xor of all, 2: ~in1, 3: const 1, other: random lookup
   function automatic logic fval(input int m, input int k, input int n);
      int kk;
      kk = k & ((1 << n) - 1);
      case (m)
         0:       return kk[0] & kk[n-1];
         1:       return ^kk;
         2:       return ~kk[0];
         3:       return 1'b1;
         default: return lut[kk];
      endcase
   endfunction

   assign if0.start = start;  assign if0.abort = abort;  assign if0.table_ready = ready;
   assign if1.start = start;  assign if1.abort = abort;  assign if1.table_ready = ready;
   assign if2.start = start;  assign if2.abort = abort;  assign if2.table_ready = ready;
   assign if0.f_in = fval(mode, int'(if0.stim), 3);
   assign if1.f_in = fval(mode, int'(if1.stim), 3);
   assign if2.f_in = fval(mode, int'(if2.stim), 1);

   truth_table_extractor #(.N_IN(3), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
   truth_table_extractor #(.N_IN(3), .SETTLE(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
   truth_table_extractor #(.N_IN(1), .SETTLE(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

   logic [63:0] dtab [3];
   logic [5:0]  dstim[3];
   logic        dbusy[3];
   logic        dvld [3];
   assign dtab[0] = 64'(if0.table_out);  assign dstim[0] = 6'(if0.stim);
   assign dtab[1] = 64'(if1.table_out);  assign dstim[1] = 6'(if1.stim);
   assign dtab[2] = 64'(if2.table_out);  assign dstim[2] = 6'(if2.stim);
   assign dbusy[0] = if0.busy;  assign dvld[0] = if0.table_valid;
   assign dbusy[1] = if1.busy;  assign dvld[1] = if1.table_valid;
   assign dbusy[2] = if2.busy;  assign dvld[2] = if2.table_valid;

   // Model: phase 0 idle / 1 sweeping / 2 done; e = cycles since the accept.
   // Stimulus k is held for cycles e in [k*(S+1)+1, (k+1)*(S+1)] and sampled
   // at the edge closing the last of those cycles.
   int          NN[3] = '{3, 3, 1};
   int          SS[3] = '{1, 3, 1};
   int          ph[3];
   int          e [3];
   logic [63:0] tbl[3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            ph[i] = 0; e[i] = 0; tbl[i] = 64'd0;
         end else begin
            case (ph[i])
               0: if (start && !abort) begin ph[i] = 1; e[i] = 1; tbl[i] = 64'd0; end
               1: begin
                  if (abort) begin
                     ph[i] = 0; e[i] = 0; tbl[i] = 64'd0;
                  end else begin
                     if (e[i] % (SS[i] + 1) == 0) begin
                        automatic int k = e[i] / (SS[i] + 1) - 1;
                        tbl[i][k] = fval(mode, k, NN[i]);
                        if (k == (1 << NN[i]) - 1) ph[i] = 2;
                     end
                     e[i] = e[i] + 1;
                  end
               end
               default: if (ready) ph[i] = 0;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            automatic int xs = (ph[i] == 1) ? (e[i] - 1) / (SS[i] + 1) :
                               (ph[i] == 2) ? (1 << NN[i]) - 1 : 0;
            chk($sformatf("stim%0d", i),  64'(dstim[i]), 64'(xs));
            chk($sformatf("busy%0d", i),  64'(dbusy[i]), 64'(ph[i] == 1));
            chk($sformatf("valid%0d", i), 64'(dvld[i]),  64'(ph[i] == 2));
            chk($sformatf("table%0d", i), dtab[i], tbl[i]);
         end
      end
   end

   function automatic logic all_vld();
      return dvld[0] && dvld[1] && dvld[2];
   endfunction

   // Pulse start, then record the cycle index at which each table_valid is first seen.
   task automatic run_sweep(input int pulse_at);
      lat = '{0, 0, 0};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         for (int i = 0; i < 3; i++) if (dvld[i] && lat[i] == 0) lat[i] = n;
         start = (n == pulse_at);
         if (all_vld()) break;
         @(negedge clk);
      end
      start = 1'b0;
      chk("sweep_done_in_budget", 64'(all_vld()), 64'd1);
   endtask

   task automatic release_table();
      repeat (10) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("idle_after_ready", 64'(dvld[0] | dvld[1] | dvld[2]), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
      mode = 0; lut = 64'd0; chk_en = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_table", dtab[0], 64'd0);

      // AND of in1/in3, with a start pulse while some units are done or busy
      mode = 0;
      run_sweep(20);
      chk("lat_3_1", 64'(lat[0]), 64'd17);
      chk("lat_3_3", 64'(lat[1]), 64'd33);
      chk("lat_1_1", 64'(lat[2]), 64'd5);
      chk("and_tab0", dtab[0], 64'hA0);
      chk("and_tab1", dtab[1], 64'hA0);
      chk("and_tab2", dtab[2], 64'h2);
      release_table();

      mode = 1;
      run_sweep(0);
      chk("xor_tab1", dtab[1], 64'h96);
      chk("xor_tab0", dtab[0], 64'h96);
      chk("xor_tab2", dtab[2], 64'h2);
      release_table();

      // abort at t+7: N_IN=1 unit is already done and must ignore it
      mode = 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy0", 64'(dbusy[0]), 64'd0);
      chk("abort_tab0",  dtab[0], 64'd0);
      chk("abort_stim1", 64'(dstim[1]), 64'd0);
      chk("abort_vld2",  64'(dvld[2]), 64'd1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      run_sweep(0);
      chk("after_abort_tab0", dtab[0], 64'hFF);
      release_table();

      // reset at t+9
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_tab1",  dtab[1], 64'd0);
      chk("rst_vld2",  64'(dvld[2]), 64'd0);
      chk("rst_busy0", 64'(dbusy[0]), 64'd0);
      run_sweep(0);
      chk("one_tab0", dtab[0], 64'hFF);
      chk("one_tab2", dtab[2], 64'h3);
      release_table();

      mode = 2;
      run_sweep(0);
      chk("not_tab2", dtab[2], 64'h1);
      chk("not_tab0", dtab[0], 64'h55);
      release_table();

      // random traffic against a random function
      mode = 4;
      lut = {$urandom, $urandom};
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         abort = ($urandom_range(0, 29) == 0);
         start = !abort && ($urandom_range(0, 3) == 0);
         ready = ($urandom_range(0, 2) == 0);
         if (ph[0] == 0 && ph[1] == 0 && ph[2] == 0 && $urandom_range(0, 9) == 0)
            lut = {$urandom, $urandom};
         @(negedge clk);
      end
      rst = 1'b0; abort = 1'b0; start = 1'b0; ready = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
